// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states,
// exception causes and the XLEN legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, access legality
// checks, and load byte-lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       addr_lo,
  input  logic [2:0]       funct3,
  input  logic             is_store,
  input  logic [XLEN-1:0]  st_data,
  output logic [XLEN-1:0]  wdata,
  output logic [NB-1:0]    be,
  output logic             misalign,
  output logic             illegal,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [2:0]       ld_funct3,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [OFF_W-1:0] st_off;
  logic [XLEN-1:0]  shifted;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] size,
                                             input logic uns);
    logic [XLEN-1:0] mask;
    logic            sign;
    case (size)
      SZ_B:    begin mask = XLEN'(8'hFF);          sign = v[7];  end
      SZ_H:    begin mask = XLEN'(16'hFFFF);       sign = v[15]; end
      SZ_W:    begin mask = XLEN'(32'hFFFF_FFFF);  sign = v[31]; end
      default: begin mask = '1;                    sign = 1'b0;  end
    endcase
    return (v & mask) | ((sign && !uns) ? ~mask : '0);
  endfunction

  assign st_off  = addr_lo[OFF_W-1:0];
  assign shifted = rdata >> {ld_off, 3'b000};
  assign ld_data = extend(shifted, ld_funct3[1:0], ld_funct3[2]);

  always_comb begin
    wdata    = st_data;
    be       = '1;
    misalign = 1'b0;
    case (funct3[1:0])
      SZ_B: begin
        wdata = {NB{st_data[7:0]}};
        be    = NB'(1) << st_off;
      end
      SZ_H: begin
        wdata    = {(NB/2){st_data[15:0]}};
        be       = NB'(3) << st_off;
        misalign = addr_lo[0];
      end
      SZ_W: begin
        wdata    = {(NB/4){st_data[31:0]}};
        be       = NB'(15) << st_off;
        misalign = |addr_lo[1:0];
      end
      default: begin
        misalign = |addr_lo[2:0];
      end
    endcase
  end

  // Stores only encode sizes 0xx; loads reserve 111, and RV32 also lacks LD/LWU.
  always_comb begin
    if (is_store)
      illegal = funct3[2] || ((XLEN == 32) && (funct3 == 3'b011));
    else
      illegal = (funct3 == 3'b111) ||
                ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: runs loads/stores over a req/gnt/rvalid bus, stalls the
// upstream pipe while an access is outstanding and registers all WB outputs.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   alu_result,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [4:0]          rd,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                mem_reg,
  input  logic [2:0]          funct3,
  output logic                mem_stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [XLEN/8-1:0]   dmem_be,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic                wb_regout,
  output logic [XLEN-1:0]     wb_data,
  output logic [ADDR_W-1:0]   wb_alu_result,
  output logic [4:0]          wb_rd,
  output logic                exc,
  output logic [1:0]          exc_cause,
  output logic [ADDR_W-1:0]   exc_addr
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  if (!xlen_ok(XLEN)) begin : g_xlen_check
    $error("mem_stage_lsu: XLEN must be 32 or 64");
  end

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              stall_c, retire, tmo_hit, tmo;
  logic              mem_op, legal_op, misalign, illegal;
  logic [XLEN-1:0]   st_wdata, ld_data;
  logic [NB-1:0]     st_be;

  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        funct3_p1;
  logic [4:0]        rd_p1;
  logic              reg_write_p1, mem_reg_p1, we_p1;
  logic [XLEN-1:0]   wdata_p1;
  logic [NB-1:0]     be_p1;

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo   (alu_result[2:0]),
    .funct3    (funct3),
    .is_store  (mem_write),
    .st_data   (rs2_data),
    .wdata     (st_wdata),
    .be        (st_be),
    .misalign  (misalign),
    .illegal   (illegal),
    .ld_off    (addr_p1[OFF_W-1:0]),
    .ld_funct3 (funct3_p1),
    .rdata     (dmem_rdata),
    .ld_data   (ld_data)
  );

  assign mem_op   = ex_valid && (mem_read || mem_write);
  assign legal_op = mem_op && !misalign && !illegal;
  assign tmo      = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Stall is gated by reset so a held upstream op cannot re-raise it during reset.
  assign mem_stall  = rst && stall_c;
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = dmem_req && we_p1;
  assign dmem_addr  = {addr_p1[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_wdata = wdata_p1;
  assign dmem_be    = be_p1;

  // Completion takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    retire  = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (legal_op) begin
          state_n = S_REQ;
          stall_c = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem_gnt && we_p1) begin
          retire  = 1'b1;
          state_n = S_IDLE;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = S_IDLE;
        end else begin
          stall_c = 1'b1;
          if (dmem_gnt) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          retire  = 1'b1;
          state_n = S_IDLE;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_p1       <= '0;
      funct3_p1     <= '0;
      rd_p1         <= '0;
      reg_write_p1  <= 1'b0;
      mem_reg_p1    <= 1'b0;
      we_p1         <= 1'b0;
      wdata_p1      <= '0;
      be_p1         <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_regout     <= 1'b0;
      wb_data       <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
      exc           <= 1'b0;
      exc_cause     <= CAUSE_NONE;
      exc_addr      <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == S_IDLE) ? '0 : cnt + 1'b1;

      // EX/MEM -> hold registers
      if ((state == S_IDLE) && legal_op) begin
        addr_p1      <= alu_result;
        funct3_p1    <= funct3;
        rd_p1        <= rd;
        reg_write_p1 <= reg_write;
        mem_reg_p1   <= mem_reg;
        we_p1        <= mem_write;
        wdata_p1     <= st_wdata;
        be_p1        <= st_be;
      end

      // MEM/WB boundary
      wb_valid <= 1'b0;
      exc      <= 1'b0;
      if (state == S_IDLE) begin
        if (ex_valid && !legal_op) begin
          wb_valid      <= 1'b1;
          wb_rd         <= rd;
          wb_alu_result <= alu_result;
          wb_data       <= '0;
          wb_regout     <= mem_reg;
          wb_reg_write  <= reg_write && !mem_op;
          if (mem_op) begin
            exc       <= 1'b1;
            exc_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            exc_addr  <= alu_result;
          end
        end
      end else if (retire) begin
        wb_valid      <= 1'b1;
        wb_rd         <= rd_p1;
        wb_alu_result <= addr_p1;
        wb_data       <= we_p1 ? '0 : ld_data;
        wb_regout     <= mem_reg_p1;
        wb_reg_write  <= reg_write_p1;
      end else if (tmo_hit) begin
        wb_valid      <= 1'b1;
        wb_rd         <= rd_p1;
        wb_alu_result <= addr_p1;
        wb_data       <= '0;
        wb_regout     <= mem_reg_p1;
        wb_reg_write  <= 1'b0;
        exc           <= 1'b1;
        exc_cause     <= CAUSE_TIMEOUT;
        exc_addr      <= addr_p1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized checks of mem_stage_lsu (XLEN=32, TIMEOUT=16)
// against an arithmetic reference model of the access rules.
module tb_mem_stage_lsu;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, reg_write, mem_read, mem_write, mem_reg;
  logic [ADDR_W-1:0] alu_result;
  logic [XLEN-1:0]   rs2_data, dmem_rdata;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic              dmem_gnt, dmem_rvalid;
  logic              mem_stall, dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr, wb_alu_result, exc_addr;
  logic [XLEN-1:0]   dmem_wdata, wb_data;
  logic [XLEN/8-1:0] dmem_be;
  logic              wb_valid, wb_reg_write, wb_regout, exc;
  logic [4:0]        wb_rd;
  logic [1:0]        exc_cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
    .rs2_data(rs2_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_reg(mem_reg), .funct3(funct3),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_regout(wb_regout),
    .wb_data(wb_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
    .exc(exc), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    reg_write = 1'b0; mem_reg = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Reference model: plain arithmetic over access size in bytes.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_illegal(input bit st, input logic [2:0] f3);
    if (st) return (f3 >= 3'd3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic bit m_misalign(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    return ((32'd1 << nbytes(f3)) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [63:0] w = 0;
    int          n = nbytes(f3);
    logic [63:0] piece = d & ((64'd1 << (8 * n)) - 1);
    for (int i = 0; i < 4 / n; i++) w = w | (piece << (8 * n * i));
    return w[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] r);
    int          bits = 8 * nbytes(f3);
    logic [63:0] v    = (64'(r) >> (8 * (a % 4))) & ((64'd1 << bits) - 1);
    if (!f3[2] && v[bits-1]) v = v | ~((64'd1 << bits) - 1);
    return v[31:0];
  endfunction

  // Presents one instruction right after an edge and follows it to WB.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdat, input int gd, input int rvd,
                        input logic [4:0] rdi);
    ex_valid = 1'b1; mem_read = ld; mem_write = st; funct3 = f3;
    alu_result = addr; rs2_data = data; rd = rdi; reg_write = !st; mem_reg = ld;
    #1;
    if (!ld && !st) begin
      chk("alu_stall", mem_stall, 0);
      tick(); idle_inputs();
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_alu", wb_alu_result, addr);
      chk("alu_wb_rd", wb_rd, rdi);
      chk("alu_wb_rw", wb_reg_write, 1);
      chk("alu_wb_data", wb_data, 0);
      chk("alu_exc", exc, 0);
      return;
    end
    if (m_illegal(st, f3) || m_misalign(f3, addr)) begin
      chk("exc_stall", mem_stall, 0);
      chk("exc_req", dmem_req, 0);
      tick(); idle_inputs();
      chk("exc_wb_valid", wb_valid, 1);
      chk("exc_pulse", exc, 1);
      chk("exc_cause", exc_cause, m_illegal(st, f3) ? 2'b11 : 2'b01);
      chk("exc_addr", exc_addr, addr);
      chk("exc_wb_rw", wb_reg_write, 0);
      tick();
      chk("exc_one_cycle", exc, 0);
      return;
    end
    chk("mem_stall_c0", mem_stall, 1);
    tick();
    for (int k = 0; k < gd; k++) begin
      chk("gnt_wait_req", dmem_req, 1);
      chk("gnt_wait_stall", mem_stall, 1);
      chk("gnt_wait_wbv", wb_valid, 0);
      tick();
    end
    dmem_gnt = 1'b1;
    #1;
    chk("req", dmem_req, 1);
    chk("req_wbv", wb_valid, 0);
    chk("req_addr", dmem_addr, addr & ~32'd3);
    chk("req_we", dmem_we, st);
    if (st) begin
      chk("st_be", dmem_be, m_be(f3, addr));
      chk("st_wdata", dmem_wdata, m_wdata(f3, data));
    end
    chk("gnt_stall", mem_stall, !st);
    tick();
    dmem_gnt = 1'b0;
    if (!st) begin
      for (int k = 0; k < rvd; k++) begin
        chk("rv_wait_stall", mem_stall, 1);
        chk("rv_wait_req", dmem_req, 0);
        chk("rv_wait_wbv", wb_valid, 0);
        tick();
      end
      dmem_rvalid = 1'b1; dmem_rdata = rdat;
      #1;
      chk("rv_stall", mem_stall, 0);
      tick();
    end
    idle_inputs();
    chk("ret_wb_valid", wb_valid, 1);
    chk("ret_wb_rw", wb_reg_write, !st);
    chk("ret_wb_data", wb_data, st ? 32'd0 : m_load(f3, addr, rdat));
    chk("ret_wb_rd", wb_rd, rdi);
    chk("ret_wb_alu", wb_alu_result, addr);
    chk("ret_exc", exc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    alu_result = '0; rs2_data = '0; rd = '0; funct3 = '0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_exc", exc, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b1;
    tick();

    // Directed steps
    run_op(0, 0, 3'b000, 32'h1234, 0, 0, 0, 0, 5'd5);
    run_op(0, 1, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 5'd0);
    run_op(1, 0, 3'b000, 32'h102, 0, 32'h0080_0000, 0, 0, 5'd7);
    run_op(1, 0, 3'b100, 32'h102, 0, 32'h0080_0000, 2, 0, 5'd8);
    run_op(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 5'd9);
    run_op(0, 1, 3'b001, 32'h302, 32'hBEEF_1234, 0, 1, 0, 5'd0);

    // Timeout: gnt in the first REQ cycle, rvalid never arrives
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h200; rd = 5'd3; reg_write = 1'b1; mem_reg = 1'b1;
    #1;
    chk("tmo_stall_c0", mem_stall, 1);
    tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      chk("tmo_stall", mem_stall, (c == 16) ? 0 : 1);
      if (c < 16) tick();
    end
    tick();
    idle_inputs();
    chk("tmo_wbv", wb_valid, 1);
    chk("tmo_exc", exc, 1);
    chk("tmo_cause", exc_cause, 2'b10);
    chk("tmo_addr", exc_addr, 32'h200);
    chk("tmo_wb_rw", wb_reg_write, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("stale_stall", mem_stall, 0);
    tick();
    dmem_rvalid = 1'b0;
    chk("stale_wbv", wb_valid, 0);
    chk("stale_exc", exc, 0);

    // Reset while in WAIT, then while in REQ
    for (int phase = 0; phase < 2; phase++) begin
      ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h400;
      reg_write = 1'b1; rd = 5'd4;
      tick();
      if (phase == 0) begin
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
      end
      chk("pre_rst_stall", mem_stall, 1);
      chk("pre_rst_req", dmem_req, phase);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", dmem_req, 0);
      chk("mid_rst_stall", mem_stall, 0);
      chk("mid_rst_wbv", wb_valid, 0);
      idle_inputs();
      tick();
      rst = 1'b1;
      tick();
      run_op(1, 0, 3'b001, 32'h406, 0, 32'h8001_0000, 0, 1, 5'd12);
    end

    // Randomized traffic with occasional bubbles
    for (int n = 0; n < 40; n++) begin
      int          kind = $urandom_range(0, 2);
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
      run_op(kind == 1, kind == 2, f3, a, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), 5'($urandom_range(1, 31)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("bubble_wbv", wb_valid, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
